// File: rtl/next_frame_tx.sv
// Frame buffer transmitter: fills a buffer of len samples, then emits them as one
// burst announced by a next_out pulse, with pulses spaced at least MIN_GAP cycles.
package next_frame_tx_pkg;
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] i;
    } complex_t;
endpackage

module next_frame_tx
    import next_frame_tx_pkg::*;
#(
    parameter int MAX_LEN_BITS = 4,
    parameter int MIN_GAP      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    input  logic [MAX_LEN_BITS:0] cfg_len,
    output logic                  busy,
    input  complex_t              in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output complex_t              out,
    output logic                  next_out
);
    localparam int DEPTH = 2 ** MAX_LEN_BITS;
    localparam int LW    = MAX_LEN_BITS + 1;
    localparam int GW    = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

    localparam logic [LW-1:0]           DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0]           ONE_L   = LW'(1);
    localparam logic [GW-1:0]           GAP_MAX = GW'(MIN_GAP);
    localparam logic [GW-1:0]           GAP_ONE = GW'(1);
    localparam logic [MAX_LEN_BITS-1:0] IDX0    = '0;

    typedef enum logic [1:0] {IDLE, FILL, WAIT, SEND} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   gap_q, gap_d;
    complex_t        out_q, out_d;
    logic            wr_en;
    logic            fire;

    complex_t mem [DEPTH];

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;
        wr_en    = 1'b0;
        fire     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid && (cfg_len != '0) && (cfg_len <= DEPTH_L)) begin
                    len_d    = cfg_len;
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_L;
                    if (wr_ptr_q == len_q - ONE_L) state_d = WAIT;
                end
            end
            WAIT: begin
                // Preload the first sample so it appears on out the cycle after the pulse.
                if (gap_q >= GAP_MAX) begin
                    fire     = 1'b1;
                    out_d    = mem[IDX0];
                    rd_ptr_d = ONE_L;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (rd_ptr_q == len_q) begin
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end else begin
                    out_d    = mem[rd_ptr_q[MAX_LEN_BITS-1:0]];
                    rd_ptr_d = rd_ptr_q + ONE_L;
                end
            end
            default: state_d = IDLE;
        endcase

        gap_d = gap_q;
        if (fire)                 gap_d = GAP_ONE;
        else if (gap_q < GAP_MAX) gap_d = gap_q + GAP_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            gap_q    <= GAP_MAX;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            gap_q    <= gap_d;
            out_q    <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[MAX_LEN_BITS-1:0]] <= in;
    end

    assign out      = out_q;
    assign next_out = fire;
    assign in_ready = (state_q == FILL);
    assign busy     = (state_q != IDLE);
endmodule

// File: doc/next_frame_tx.md
NEXT_FRAME_TX -- requirements
Module: next_frame_tx

Interface
REQ-001 SHALL have parameter MAX_LEN_BITS, default 4, meaning buffer depth DEPTH = 2**MAX_LEN_BITS complex samples.
REQ-002 SHALL have parameter MIN_GAP, default 12, meaning minimum cycle distance between successive next_out pulses.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  frame-length configuration strobe.
REQ-006 SHALL have port cfg_len  input  MAX_LEN_BITS+1  requested frame length, legal range 1..DEPTH.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port in  input  complex_t (64: r[31:0], i[31:0])  sample to buffer.
REQ-009 SHALL have port in_valid  input  1  in carries a sample this cycle.
REQ-010 SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-011 SHALL have port out  output  complex_t  registered frame sample.
REQ-012 SHALL have port next_out  output  1  one-cycle pulse; the following len consecutive cycles carry frame samples on out.

Function
REQ-013 SHALL implement states IDLE, FILL, WAIT, SEND.
REQ-014 IDLE: in_ready=0; cfg_valid with 1<=cfg_len<=DEPTH SHALL latch len, clear write pointer, go to FILL; cfg_len=0 or >DEPTH SHALL be ignored (stay IDLE).
REQ-015 FILL: in_ready=1; each cycle with in_valid=1 SHALL write in to buffer[wr_ptr] and increment wr_ptr.
REQ-016 FILL: acceptance of the len-th sample SHALL transition to WAIT on the next edge; in_ready SHALL be 0 from that next cycle.
REQ-017 WAIT: in_ready=0; SHALL assert next_out for exactly one cycle in the first WAIT cycle where gap counter >= MIN_GAP, then go to SEND.
REQ-018 Gap counter SHALL reset to 1 in the cycle after a next_out pulse, increment by 1 per cycle, saturate at MIN_GAP; after reset it SHALL equal MIN_GAP.
REQ-019 SEND: for k=0..len-1, out SHALL equal buffer[k] in the k-th cycle after next_out (cycle next_out+1+k), with no bubbles.
REQ-020 After the last sample SHALL return to FILL with same len and wr_ptr=0 (continuous framing); in_ready SHALL be 1 in the cycle after the last out sample.
REQ-021 Reconfiguration SHALL only occur in IDLE; cfg_valid outside IDLE SHALL be ignored.
REQ-022 out SHALL hold its last driven value outside SEND; its value there is don't-care for consumers.
REQ-023 Samples SHALL be transported bit-exact; no arithmetic on data.
REQ-024 len=1: next_out pulse followed by exactly one sample cycle.
REQ-025 len=DEPTH: all buffer entries used; wr_ptr wrap SHALL not overwrite before SEND completes.
REQ-026 in_valid while in_ready=0 SHALL be ignored, no buffer write.
REQ-027 busy SHALL be 1 in FILL, WAIT, SEND; 0 in IDLE.

Reset
REQ-028 reset=1 at a posedge SHALL force state IDLE, len=0, wr_ptr=0, rd_ptr=0, gap counter=MIN_GAP, next_out=0, in_ready=0, busy=0, out=64'h0.
REQ-029 reset mid-FILL or mid-SEND SHALL abort the frame; no next_out or further samples until reconfigured and refilled.
REQ-030 Buffer contents need not be reset.

Verification
REQ-031 Reset, cfg_len=4, feed 32'h43480000+k on r and i for k=0..3 back-to-back -> next_out one cycle, then out = k=0..3 on 4 consecutive cycles, in_ready=1 the cycle after.
REQ-032 cfg_len=1, two consecutive frames -> next_out pulses exactly MIN_GAP=12 cycles apart (WAIT stall), one sample each.
REQ-033 cfg_len=16 (DEPTH), random in_valid gaps -> 16 samples in order, no bubbles after next_out, in_ready=0 from WAIT through SEND.
REQ-034 cfg_valid with cfg_len=0 and cfg_len=17 in IDLE -> busy stays 0; cfg_valid with cfg_len=8 during FILL -> len stays 4.
REQ-035 reset asserted in 2nd SEND cycle of len=4 frame -> next cycle all outputs at reset values, no further next_out until new cfg and fill.
REQ-036 in_valid held during WAIT/SEND with distinct data -> data not written; next frame contains only FILL-accepted samples.
